mig_frame_writer: RTL
=====================

# mig_frame_writer

Parametrised streaming frame writer between the Mandelbrot rendering engine and one write port of the DDR2 MIG video RAM. It waits for memory calibration, then packs renderer words into the MIG write FIFO, issues burst write commands, and writes successive frames into a ring of frame buffers. After each completed frame it publishes the finished buffer's base address for the display side. It replaces the single-word, fixed-address write sequencing in the top-level controller.

## Interface
- DATA_W, 64, MIG port data width in bits (multiple of 8)
- ADDR_W, 30, MIG byte-address width
- BURST_LEN, 16, max beats per write command (1..64)
- FRAME_WORDS, 38400, data words per full frame
- NUM_BUFS, 2, frame buffers in the ring (1..4)
- BASE_ADDR, 0, byte address of buffer 0
- BUF_STRIDE, 'h50000, byte distance between buffers (≥ FRAME_WORDS·DATA_W/8)

- clk0  in  1  MIG user clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- calib_done  in  1  MIG calibration flag, asynchronous; 2-flop synchronised internally
- src_data  in  DATA_W  renderer word
- src_valid  in  1  src_data valid
- src_last  in  1  marks final word of a frame (qualified by src_valid)
- src_ready  out  1  word accepted when src_valid && src_ready
- wr_en  out  1  MIG write-FIFO push
- wr_data  out  DATA_W  MIG write data
- wr_mask  out  DATA_W/8  constant 0
- wr_full  in  1  MIG write FIFO full
- cmd_en  out  1  MIG command strobe
- cmd_instr  out  3  constant 3'b000 (write)
- cmd_bl  out  6  burst length minus one
- cmd_byte_addr  out  ADDR_W  burst start byte address
- cmd_full  in  1  MIG command FIFO full
- display_base  out  ADDR_W  base of most recently completed buffer
- frame_done  out  1  one-cycle pulse per completed frame
- short_frame  out  1  sticky: frame ended by src_last before FRAME_WORDS
- busy  out  1  high outside WAIT_CAL/FILL-with-zero-beats

## Operation
- States: WAIT_CAL, FILL, CMD, FLIP.
- WAIT_CAL: src_ready=0. Exit to FILL when synchronised calib_done high; later deassertion ignored.
- FILL: src_ready = !wr_full && beats < BURST_LEN. Each accepted word drives wr_en=1, wr_data=src_data same cycle (combinational pass-through; wr_en = src_valid && src_ready), beats++, word_off++.
- FILL→CMD when accepted word makes beats==BURST_LEN, or is src_last, or makes word_off==FRAME_WORDS. Latch frame_end flag if either of the latter two.
- CMD: cmd_en=1 while !cmd_full, held one cycle only (drop the strobe once accepted). cmd_bl = beats−1; cmd_byte_addr = buf_base + (word_off−beats)·DATA_W/8, buf_base = BASE_ADDR + buf_idx·BUF_STRIDE, arithmetic in ADDR_W bits, wrap modulo 2^ADDR_W. On issue, beats←0; to FLIP if frame_end else FILL.
- FLIP (1 cycle): display_base←buf_base; frame_done=1; buf_idx←(buf_idx+1) mod NUM_BUFS; word_off←0; short_frame set if word_off<FRAME_WORDS; →FILL.
- src_last with word_off==FRAME_WORDS simultaneously: single frame end, short_frame not set.
- Words after FRAME_WORDS without src_last begin the next frame (no drop).
- NUM_BUFS=1: always rewrites buffer 0; display_base stays BASE_ADDR.

## Timing
- Reset values: src_ready 0, wr_en 0, wr_data 0, cmd_en 0, cmd_bl 0, cmd_byte_addr 0, display_base BASE_ADDR, frame_done 0, short_frame 0, busy 0; state WAIT_CAL, buf_idx 0, counters 0, sync flops 0.
- Calibration latency: FILL entered 3 cycles after calib_done rises (2 sync + state register).
- Command issued ≥1 cycle after last data beat of the burst; data always precedes its command.
- Throughput: BURST_LEN beats + 1 CMD cycle per burst when FIFOs not full; +1 FLIP cycle per frame.
- wr_full high: no push that cycle; cmd_full high: CMD holds, outputs stable.
- Reset mid-burst: all state cleared same edge; uncommitted words left in MIG FIFO are not flushed — MIG port must be reset together.

## Test plan
- calib_done held 0 for 100 cycles with src_valid=1 -> src_ready stays 0, no wr_en; rise -> src_ready 1 three cycles later.
- BURST_LEN=16, FRAME_WORDS=64, continuous stream -> 4 commands, cmd_bl=15, addresses 0,128,256,384; frame_done once; display_base=0; next frame at BUF_STRIDE.
- src_last on word 20 of FRAME_WORDS=64 -> bursts bl 15 then bl 3 at addr 128; short_frame=1; next frame starts at offset 0 of buffer 1.
- wr_full toggled randomly and cmd_full held 10 cycles -> no beat lost/duplicated, cmd_en single-cycle on acceptance, data matches scoreboard.
- NUM_BUFS=3, five frames -> display_base sequence 0, S, 2S, 0, S.
- reset asserted mid-burst (beat 7) -> all outputs at reset values next cycle, state WAIT_CAL, restart writes from buffer 0 offset 0.

Source files
------------

// File: rtl/mig_frame_writer.sv
// mig_frame_writer
//   Streams renderer words into one MIG write port. After calibration it
//   pushes words into the MIG write FIFO, issues a burst write command every
//   BURST_LEN beats (or at frame end), and cycles through NUM_BUFS frame
//   buffers, publishing the base of each finished buffer on display_base.
// Ports:
//   clk0, reset                 MIG user clock, sync active-high reset
//   calib_done                  async calibration flag (2-flop synchronised)
//   src_data/valid/last/ready   renderer stream (ready/valid handshake)
//   wr_en/wr_data/wr_mask/wr_full            MIG write-data FIFO
//   cmd_en/instr/bl/byte_addr/cmd_full       MIG command FIFO
//   display_base, frame_done    last completed buffer base, 1-cycle pulse
//   short_frame                 sticky: a frame ended early on src_last
//   busy                        burst or frame turnaround in progress
module mig_frame_writer #(
  parameter int              DATA_W      = 64,
  parameter int              ADDR_W      = 30,
  parameter int              BURST_LEN   = 16,
  parameter int              FRAME_WORDS = 38400,
  parameter int              NUM_BUFS    = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = 'h50000
) (
  input  logic                  clk0,
  input  logic                  reset,
  input  logic                  calib_done,
  input  logic [DATA_W-1:0]     src_data,
  input  logic                  src_valid,
  input  logic                  src_last,
  output logic                  src_ready,
  output logic                  wr_en,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_mask,
  input  logic                  wr_full,
  output logic                  cmd_en,
  output logic [2:0]            cmd_instr,
  output logic [5:0]            cmd_bl,
  output logic [ADDR_W-1:0]     cmd_byte_addr,
  input  logic                  cmd_full,
  output logic [ADDR_W-1:0]     display_base,
  output logic                  frame_done,
  output logic                  short_frame,
  output logic                  busy
);
  localparam int OFF_W  = $clog2(FRAME_WORDS + 1);
  localparam int BEAT_W = 7;
  localparam int BYTES  = DATA_W / 8;

  typedef enum logic [1:0] {WAIT_CAL, FILL, CMD, FLIP} state_t;

  state_t              r_state, w_state_n;
  logic                r_cal_s1, r_cal_s2;
  logic [BEAT_W-1:0]   r_beats;
  logic [OFF_W-1:0]    r_word_off;
  logic [1:0]          r_buf_idx;
  logic                r_frame_end;
  logic [ADDR_W-1:0]   r_display_base;
  logic                r_short;

  logic                w_accept;
  logic [BEAT_W-1:0]   w_beats_inc;
  logic [BEAT_W-1:0]   w_bl_full;
  logic [OFF_W-1:0]    w_off_inc;
  logic                w_burst_full, w_frame_full, w_close;
  logic [ADDR_W-1:0]   w_buf_base, w_burst_off;

  assign w_beats_inc  = r_beats + BEAT_W'(1);
  assign w_off_inc    = r_word_off + OFF_W'(1);
  assign w_burst_full = (w_beats_inc == BEAT_W'(BURST_LEN));
  assign w_frame_full = (w_off_inc == OFF_W'(FRAME_WORDS));
  // src_last coinciding with the full word count closes the frame only once
  assign w_close      = w_burst_full || src_last || w_frame_full;
  assign w_accept     = src_valid && src_ready;
  assign w_bl_full    = r_beats - BEAT_W'(1);

  // all address math in ADDR_W bits, so it wraps modulo 2^ADDR_W
  assign w_buf_base  = BASE_ADDR + ADDR_W'(r_buf_idx) * BUF_STRIDE;
  assign w_burst_off = ADDR_W'(r_word_off - OFF_W'(r_beats)) * ADDR_W'(BYTES);

  // data path is a pass-through; zero outside pushes keeps idle bus quiet
  assign wr_en         = w_accept;
  assign wr_data       = w_accept ? src_data : '0;
  assign wr_mask       = '0;
  assign cmd_instr     = 3'b000;
  assign cmd_bl        = (r_state == CMD) ? w_bl_full[5:0] : 6'd0;
  assign cmd_byte_addr = (r_state == CMD) ? (w_buf_base + w_burst_off) : '0;
  assign display_base  = r_display_base;
  assign short_frame   = r_short;
  assign busy          = !((r_state == WAIT_CAL) ||
                           ((r_state == FILL) && (r_beats == '0)));

  always_comb begin
    w_state_n  = r_state;
    src_ready  = 1'b0;
    cmd_en     = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      WAIT_CAL: if (r_cal_s2) w_state_n = FILL;
      FILL: begin
        src_ready = !wr_full && (r_beats < BEAT_W'(BURST_LEN));
        if (src_valid && src_ready && w_close) w_state_n = CMD;
      end
      CMD: begin
        cmd_en = !cmd_full;
        if (!cmd_full) w_state_n = r_frame_end ? FLIP : FILL;
      end
      FLIP: begin
        frame_done = 1'b1;
        w_state_n  = FILL;
      end
      default: w_state_n = WAIT_CAL;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      r_state        <= WAIT_CAL;
      r_cal_s1       <= 1'b0;
      r_cal_s2       <= 1'b0;
      r_beats        <= '0;
      r_word_off     <= '0;
      r_buf_idx      <= '0;
      r_frame_end    <= 1'b0;
      r_display_base <= BASE_ADDR;
      r_short        <= 1'b0;
    end else begin
      r_cal_s1 <= calib_done;
      r_cal_s2 <= r_cal_s1;
      r_state  <= w_state_n;
      case (r_state)
        FILL: if (w_accept) begin
          r_beats    <= w_beats_inc;
          r_word_off <= w_off_inc;
          if (w_close) r_frame_end <= src_last || w_frame_full;
        end
        CMD: if (!cmd_full) r_beats <= '0;
        FLIP: begin
          r_display_base <= w_buf_base;
          r_buf_idx      <= (r_buf_idx == 2'(NUM_BUFS - 1)) ? 2'd0 : r_buf_idx + 2'd1;
          r_word_off     <= '0;
          r_frame_end    <= 1'b0;
          if (r_word_off < OFF_W'(FRAME_WORDS)) r_short <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
